skinny_sbox8_ti2_sequencer: RTL and testbench

Sequencer that pushes a full 128-bit, 3-share SKINNY state through one shared skinny_sbox8_ti2_non_pipelined instance, one byte (cell) at a time.
- Latches the shared state on start.
- For each cell, holds the S-box share inputs stable for the S-box register depth, then captures the output shares back into the state.
- Reports done when all 16 cells are substituted.
- Sits between the round-function datapath and the single S-box, giving the SubCells step of a serialised masked SKINNY-128-384+ core.

---
 rtl/skinny_sbox8_ti2_sequencer.sv | 117 +++++++++++
 tb/tb_skinny_sbox8_ti2_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/skinny_sbox8_ti2_sequencer.sv
// Serialises a 3-share SKINNY state through one shared TI2 S-box, one cell at a time.
// The working registers rotate left by one cell per capture, so the order is restored after NCELLS shifts.
module skinny_sbox8_ti2_sequencer #(
    parameter int unsigned NCELLS   = 16,
    parameter int unsigned SBOX_LAT = 4,
    parameter int unsigned CW       = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [8*NCELLS-1:0]   si0,
    input  logic [8*NCELLS-1:0]   si1,
    input  logic [8*NCELLS-1:0]   si2,
    output logic                  busy,
    output logic                  done,
    output logic [8*NCELLS-1:0]   so0,
    output logic [8*NCELLS-1:0]   so1,
    output logic [8*NCELLS-1:0]   so2,
    output logic [7:0]            sb_si0,
    output logic [7:0]            sb_si1,
    output logic [7:0]            sb_si2,
    input  logic [7:0]            sb_bo0,
    input  logic [7:0]            sb_bo1,
    input  logic [7:0]            sb_bo2
);

    localparam int unsigned SW = 8 * NCELLS;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [CW-1:0] LAST_CELL = CW'(NCELLS - 1);
    localparam logic [CW-1:0] WAIT_MAX  = CW'(SBOX_LAT);

    logic [0:0]    r_state;
    logic [CW-1:0] r_cell;
    logic [CW-1:0] r_wait;
    logic          r_done;
    logic [SW-1:0] r_w0;
    logic [SW-1:0] r_w1;
    logic [SW-1:0] r_w2;
    logic [7:0]    r_sb0;
    logic [7:0]    r_sb1;
    logic [7:0]    r_sb2;

    logic          w_capture;
    logic          w_last;

    assign w_capture = (r_state == S_RUN) && (r_wait == WAIT_MAX);
    assign w_last    = (r_cell == LAST_CELL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cell  <= '0;
            r_wait  <= '0;
            r_done  <= 1'b0;
            r_w0    <= '0;
            r_w1    <= '0;
            r_w2    <= '0;
            r_sb0   <= '0;
            r_sb1   <= '0;
            r_sb2   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_w0    <= si0;
                        r_w1    <= si1;
                        r_w2    <= si2;
                        r_sb0   <= si0[SW-1 -: 8];
                        r_sb1   <= si1[SW-1 -: 8];
                        r_sb2   <= si2[SW-1 -: 8];
                        r_cell  <= '0;
                        r_wait  <= '0;
                        r_state <= S_RUN;
                    end
                end
                default: begin
                    if (!w_capture) begin
                        r_wait <= r_wait + CW'(1);
                    end else begin
                        // Result enters the low cell; the next top cell is the one just below the current top.
                        r_w0   <= {r_w0[SW-9:0], sb_bo0};
                        r_w1   <= {r_w1[SW-9:0], sb_bo1};
                        r_w2   <= {r_w2[SW-9:0], sb_bo2};
                        r_wait <= '0;
                        if (w_last) begin
                            r_sb0   <= '0;
                            r_sb1   <= '0;
                            r_sb2   <= '0;
                            r_cell  <= '0;
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_sb0  <= r_w0[SW-9 -: 8];
                            r_sb1  <= r_w1[SW-9 -: 8];
                            r_sb2  <= r_w2[SW-9 -: 8];
                            r_cell <= r_cell + CW'(1);
                        end
                    end
                end
            endcase
        end
    end

    assign busy   = (r_state == S_RUN);
    assign done   = r_done;
    assign so0    = r_w0;
    assign so1    = r_w1;
    assign so2    = r_w2;
    assign sb_si0 = r_sb0;
    assign sb_si1 = r_sb1;
    assign sb_si2 = r_sb2;

endmodule

// File: tb/tb_skinny_sbox8_ti2_sequencer.sv
// Bench for skinny_sbox8_ti2_sequencer with a 4-register-deep masked S-box model behind it.
module tb_skinny_sbox8_ti2_sequencer;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [127:0] si0, si1, si2;
    logic         busy, done;
    logic [127:0] so0, so1, so2;
    logic [7:0]   sb_si0, sb_si1, sb_si2;
    logic [7:0]   sb_bo0, sb_bo1, sb_bo2;

    int checks = 0;
    int errors = 0;

    skinny_sbox8_ti2_sequencer #(.NCELLS(16), .SBOX_LAT(4), .CW(5)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .si0    (si0),
        .si1    (si1),
        .si2    (si2),
        .busy   (busy),
        .done   (done),
        .so0    (so0),
        .so1    (so1),
        .so2    (so2),
        .sb_si0 (sb_si0),
        .sb_si1 (sb_si1),
        .sb_si2 (sb_si2),
        .sb_bo0 (sb_bo0),
        .sb_bo1 (sb_bo1),
        .sb_bo2 (sb_bo2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SKINNY S8: four NOR/XOR layers, bit permutation between them, bits 1/2 swapped at the end.
    function automatic logic [7:0] s8(input logic [7:0] x);
        logic [7:0] y;
        y = x;
        for (int i = 0; i < 4; i++) begin
            y[4] = y[4] ^ ~(y[7] | y[6]);
            y[0] = y[0] ^ ~(y[3] | y[2]);
            if (i < 3) y = {y[2], y[1], y[7], y[6], y[4], y[0], y[3], y[5]};
            else       y = {y[7:3], y[1], y[2], y[0]};
        end
        return y;
    endfunction

    function automatic logic [127:0] ref_state(input logic [127:0] p);
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < 16; k++) r[127-8*k -: 8] = s8(p[127-8*k -: 8]);
        return r;
    endfunction

    function automatic logic [23:0] sbox_model(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        logic [7:0] o0, o1, o2;
        o1 = {b[6:0], b[7]} ^ c;
        o2 = c ^ 8'h5A;
        o0 = s8(a ^ b ^ c) ^ o1 ^ o2;
        return {o0, o1, o2};
    endfunction

    // Unreset S-box pipeline: stale contents are flushed by the wait cycles.
    logic [23:0] p1, p2, p3, p4;
    always @(posedge clk) begin
        p1 <= sbox_model(sb_si0, sb_si1, sb_si2);
        p2 <= p1;
        p3 <= p2;
        p4 <= p3;
    end
    assign sb_bo0 = p4[23:16];
    assign sb_bo1 = p4[15:8];
    assign sb_bo2 = p4[7:0];

    typedef struct {
        logic [127:0] si0;
        logic [127:0] si1;
        logic [127:0] si2;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic launch(input logic [127:0] a, input logic [127:0] b, input logic [127:0] c);
        si0   = a;
        si1   = b;
        si2   = c;
        start = 1'b1;
    endtask

    // mode 0: plain run; 1: stray start pulses at cycles 10/40/79; 2: relaunch with n* in the done cycle
    task automatic track(input vec_t v, input int mode, input vec_t nv, input string tag);
        int viol;
        int busy_cnt;
        int done_n;
        int k;
        logic [23:0] esb;
        logic [127:0] res;
        viol     = 0;
        busy_cnt = 0;
        done_n   = -1;
        @(posedge clk);
        for (int n = 0; n <= 80; n++) begin
            @(negedge clk);
            if (n == 0) start = 1'b0;
            if (mode == 1) begin
                if (n == 10 || n == 40 || n == 79) begin
                    start = 1'b1;
                    si0   = {4{$urandom}};
                    si1   = {4{$urandom}};
                    si2   = {4{$urandom}};
                end else begin
                    start = 1'b0;
                end
            end
            if (busy) busy_cnt++;
            if (done && done_n < 0) done_n = n;
            if (n < 80) begin
                k   = n / 5;
                esb = {v.si0[127-8*k -: 8], v.si1[127-8*k -: 8], v.si2[127-8*k -: 8]};
                if (!busy || done || {sb_si0, sb_si1, sb_si2} !== esb) begin
                    if (viol == 0)
                        $display("%s: timing violation at n=%0d busy=%b done=%b sb=%h want %h",
                                 tag, n, busy, done, {sb_si0, sb_si1, sb_si2}, esb);
                    viol++;
                end
            end else begin
                if (busy || !done || {sb_si0, sb_si1, sb_si2} !== 24'h0) begin
                    if (viol == 0)
                        $display("%s: end-of-run violation busy=%b done=%b sb=%h",
                                 tag, busy, done, {sb_si0, sb_si1, sb_si2});
                    viol++;
                end
            end
        end
        res = so0 ^ so1 ^ so2;
        chk({tag, " timing"}, 128'(viol), 128'(0));
        chk({tag, " busy_cycles"}, 128'(busy_cnt), 128'(80));
        chk({tag, " done_cycle"}, 128'(done_n), 128'(80));
        chk({tag, " result"}, res, v.exp);
        if (mode == 2) begin
            launch(nv.si0, nv.si1, nv.si2);
        end else begin
            @(negedge clk);
            chk({tag, " single_done"}, 128'({busy, done}), 128'(0));
            chk({tag, " so_held"}, so0 ^ so1 ^ so2, res);
        end
    endtask

    initial begin
        logic [127:0] p, m1, m2, mA, mB;
        vec_t rv;
        int seen;

        rst_n = 1'b0;
        start = 1'b0;
        si0   = '0;
        si1   = '0;
        si2   = '0;
        repeat (3) @(negedge clk);
        chk("reset_ctl", 128'({busy, done, sb_si0, sb_si1, sb_si2}), 128'(0));
        chk("reset_so", so0 | so1 | so2, 128'(0));
        rst_n = 1'b1;
        @(negedge clk);

        mA = 128'h0123456789ABCDEF0011223344556677;
        mB = 128'hFEDCBA98765432100F1E2D3C4B5A6978;
        vecs[0] = '{si0: {8'hFF, 120'h0}, si1: '0, si2: '0, exp: {8'hFF, {15{8'h65}}}};
        p = {16{8'hFF}};
        vecs[1] = '{si0: p ^ mA ^ mB, si1: mA, si2: mB, exp: {16{8'hFF}}};
        p = '0;
        vecs[2] = '{si0: p ^ mB, si1: mB, si2: '0, exp: {16{8'h65}}};
        p = {16{8'h01}};
        vecs[3] = '{si0: p ^ mA ^ mB, si1: mA, si2: mB, exp: {16{8'h4C}}};
        p = {8{8'h00, 8'hFF}};
        vecs[4] = '{si0: p ^ mA, si1: mA ^ mB, si2: mB, exp: {8{8'h65, 8'hFF}}};

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            launch(vecs[i].si0, vecs[i].si1, vecs[i].si2);
            track(vecs[i], 0, vecs[i], $sformatf("vec%0d", i));
        end

        for (int r = 0; r < 200; r++) begin
            p  = {$urandom, $urandom, $urandom, $urandom};
            m1 = {$urandom, $urandom, $urandom, $urandom};
            m2 = {$urandom, $urandom, $urandom, $urandom};
            rv = '{si0: p ^ m1 ^ m2, si1: m1, si2: m2, exp: ref_state(p)};
            @(negedge clk);
            launch(rv.si0, rv.si1, rv.si2);
            track(rv, 0, rv, $sformatf("rand%0d", r));
        end

        @(negedge clk);
        launch(vecs[3].si0, vecs[3].si1, vecs[3].si2);
        track(vecs[3], 1, vecs[3], "stray_start");

        @(negedge clk);
        launch(vecs[1].si0, vecs[1].si1, vecs[1].si2);
        track(vecs[1], 2, vecs[4], "b2b_first");
        track(vecs[4], 0, vecs[4], "b2b_second");

        @(negedge clk);
        launch(vecs[0].si0, vecs[0].si1, vecs[0].si2);
        @(posedge clk);
        for (int n = 0; n <= 37; n++) begin
            @(negedge clk);
            if (n == 0) start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        chk("midrst_ctl", 128'({busy, done, sb_si0, sb_si1, sb_si2}), 128'(0));
        chk("midrst_so", so0 | so1 | so2, 128'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        chk("midrst_no_done", 128'(seen), 128'(0));
        launch(vecs[2].si0, vecs[2].si1, vecs[2].si2);
        track(vecs[2], 0, vecs[2], "after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
